clock_gen_mux: RTL and testbench
================================

Name: clock_gen_mux

Overview:
- Synthesizable, single-clock model of the core clock-management path: fractional-rate clock generation, clock buffering and step/run clock selection.
- Instead of producing new clock nets, it produces qualified clock-enable strobes in the `clock` domain.
  - `fx_enable` runs at clock × MULTIPLY / DIVIDE.
  - `game_enable` is selected glitch-free between `fx_enable` and a manual step source.
- It also generates a lock indicator and a held-off reset.
- Sits between the board clock input and the core/debug logic.

Parameters:
- CLKFX_MULTIPLY, 2, numerator M of enable rate; 1 ≤ M ≤ DIVIDE.
- CLKFX_DIVIDE, 6, denominator D of enable rate; 1 ≤ D ≤ 256.
- LOCK_CYCLES, 16, clock cycles after reset release before `locked` asserts; ≥ 1.
- CLKDV_DIVIDE, 3, integer divisor for the optional divided enable; ≥ 2.

Ports:
- clock, input, 1, sole clock; all logic rising-edge.
- reset, input, 1, asynchronous active-high reset.
- step_enable, input, 1, select: 0 = run from fx_enable, 1 = manual step; asynchronous to `clock`.
- step_level, input, 1, manual step level (debounced switch); asynchronous to `clock`.
- fx_enable, output, 1, one-cycle strobe at M/D rate.
- game_enable, output, 1, selected enable strobe.
- sel_active, output, 1, currently applied select value.
- locked, output, 1, high once the lock counter has expired.
- reset_out, output, 1, active-high reset to downstream logic, high until locked.
- clkdv_enable, output, 1, present only with CLKDV_EN.

Behaviour:
- Reset is asynchronous. While `reset` is high, every register is 0, except that `reset_out` = 1.
  - All registered outputs are 0 during reset.
- Lock counter:
  - Counts cycles after reset deasserts.
  - `locked` goes 1 on the edge where the count reaches LOCK_CYCLES, then holds until reset.
  - `reset_out` = !locked, registered.
  - With LOCK_CYCLES = 16, `reset_out` falls 16 cycles after reset release.
- Fractional accumulator:
  - Advances only while `locked` = 1; `acc` has ceil(log2(D)) + 1 bits.
  - Each enabled cycle computes `sum = acc + M`.
  - If `sum ≥ D`: `acc <= sum - D` and `fx_enable` = 1 for the next cycle.
  - Otherwise `acc <= sum` and `fx_enable` = 0.
  - `fx_enable` is registered and is never high two cycles in a row unless M/D > 1/2.
  - M = D gives a constant-high `fx_enable`.
  - For defaults: first strobe on the 3rd locked cycle, then every 3 cycles.
  - Over any D-cycle window there are exactly M strobes.
- Step path:
  - `step_level` is passed through a 2-FF synchronizer, then rising-edge detected.
  - This gives a one-cycle `step_pulse`, latency 3 cycles from the input edge.
- Select path (glitch-free, BUFGMUX-equivalent):
  - `step_enable` is passed through a 2-FF synchronizer to give `sel_req`.
  - `sel_active` updates to `sel_req` only on a cycle where both `fx_enable` and `step_pulse` are 0.
  - `game_enable` = `sel_active ? step_pulse : fx_enable`, registered (1-cycle latency).
  - No strobe is ever duplicated or truncated across a select change.
  - A step edge arriving while `sel_active` = 0 is discarded.
- Before `locked`, `game_enable` = 0 regardless of select.
- Simultaneous select change and pending strobe: the strobe is delivered on the old source, and the switch occurs on the next idle cycle.
- Reset mid-operation: the accumulator, synchronizers and `sel_active` clear immediately, and the lock sequence restarts.

Optional Feature:
- Macro: CLOCK_GEN_MUX_CLKDV_EN.
- When defined:
  - Adds output `clkdv_enable`, a one-cycle strobe every CLKDV_DIVIDE locked cycles, from a modulo counter starting at 0.
  - The strobe occurs when the counter equals CLKDV_DIVIDE - 1.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is unchanged.

Test Plan:
- Reset release with defaults → `reset_out` = 1 for 16 cycles, then 0; `locked` rises on cycle 16; no `game_enable` before then.
- Run mode (step_enable = 0), M = 2, D = 6 → `fx_enable` and `game_enable` pulse every 3rd cycle; exactly 20 strobes in 60 locked cycles; `game_enable` lags `fx_enable` by 1 cycle.
- Parameter sweep M = 3, D = 7 → exactly 3 strobes per 7-cycle window, never 2 adjacent.
- Select switch to step, then toggle `step_level` 0→1 → `sel_active` = 1 within 3 cycles (at an idle slot); exactly one `game_enable` pulse 4 cycles after the edge; no `fx` pulses leak through.
- Switch select back to 0 coincident with an `fx` strobe → that strobe is not truncated; `sel_active` changes on the following idle cycle; no double pulse.
- Assert `reset` asynchronously mid-run → all outputs 0 and `reset_out` = 1 immediately, with no clock edge required. With CLOCK_GEN_MUX_CLKDV_EN and CLKDV_DIVIDE = 3, `clkdv_enable` pulses every 3rd cycle after relock.

Source files
------------

// File: rtl/clock_gen_mux.sv
// clock_gen_mux: clock-management path modelled as clock-enable strobes.
// Produces a fractional-rate enable (CLKFX_MULTIPLY / CLKFX_DIVIDE), a
// glitch-free run/step selected game enable, a lock indicator and a
// held-off downstream reset.
// Optional feature macro: CLOCK_GEN_MUX_CLKDV_EN adds the CLKDV_DIVIDE
// parameter and the clkdv_enable integer-divided strobe.
module clock_gen_mux #(
  parameter int CLKFX_MULTIPLY = 2,
  parameter int CLKFX_DIVIDE   = 6,
  parameter int LOCK_CYCLES    = 16
`ifdef CLOCK_GEN_MUX_CLKDV_EN
  ,
  parameter int CLKDV_DIVIDE   = 3
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic step_enable,
  input  logic step_level,
  output logic fx_enable,
  output logic game_enable,
  output logic sel_active,
  output logic locked,
  output logic reset_out
`ifdef CLOCK_GEN_MUX_CLKDV_EN
  ,
  output logic clkdv_enable
`endif
);

  localparam int ACC_W  = $clog2(CLKFX_DIVIDE) + 1;
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [ACC_W-1:0]  M_VAL     = ACC_W'(CLKFX_MULTIPLY);
  localparam logic [ACC_W-1:0]  D_VAL     = ACC_W'(CLKFX_DIVIDE);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  logic [LOCK_W-1:0] lock_count;
  logic              lock_next;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic              fx_hit;
  logic              step_meta;
  logic              step_sync;
  logic              step_sync_d;
  logic              step_pulse;
  logic              sel_meta;
  logic              sel_req;
  logic              sel_idle;

  // Lock is reached on the edge where the post-reset cycle count hits LOCK_CYCLES.
  always_comb begin
    lock_next = locked | (lock_count == LOCK_LAST);
  end

  // Lock counter; reset_out is registered from the same next-lock value so both move together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_count <= '0;
      locked     <= 1'b0;
      reset_out  <= 1'b1;
    end else begin
      if (!locked) begin
        lock_count <= lock_count + LOCK_W'(1);
      end
      locked    <= lock_next;
      reset_out <= !lock_next;
    end
  end

  // Next accumulator value and whether it wraps past the divisor this cycle.
  always_comb begin
    acc_sum = acc + M_VAL;
    fx_hit  = (acc_sum >= D_VAL);
  end

  // Fractional accumulator: one strobe per wrap, so M strobes per D locked cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      fx_enable <= 1'b0;
    end else if (locked) begin
      acc       <= fx_hit ? (acc_sum - D_VAL) : acc_sum;
      fx_enable <= fx_hit;
    end else begin
      fx_enable <= 1'b0;
    end
  end

  // Step switch: 2-FF synchronizer followed by a registered rising-edge detector.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_meta   <= 1'b0;
      step_sync   <= 1'b0;
      step_sync_d <= 1'b0;
      step_pulse  <= 1'b0;
    end else begin
      step_meta   <= step_level;
      step_sync   <= step_meta;
      step_sync_d <= step_sync;
      step_pulse  <= step_sync & ~step_sync_d;
    end
  end

  // The select may only move when neither source has a strobe in flight.
  always_comb begin
    sel_idle = !fx_enable && !step_pulse;
  end

  // Select synchronizer, idle-slot select update and the registered selected enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_meta    <= 1'b0;
      sel_req     <= 1'b0;
      sel_active  <= 1'b0;
      game_enable <= 1'b0;
    end else begin
      sel_meta <= step_enable;
      sel_req  <= sel_meta;
      if (sel_idle) begin
        sel_active <= sel_req;
      end
      game_enable <= locked & (sel_active ? step_pulse : fx_enable);
    end
  end

`ifdef CLOCK_GEN_MUX_CLKDV_EN
  localparam int DV_W = $clog2(CLKDV_DIVIDE);
  localparam logic [DV_W-1:0] DV_LAST = DV_W'(CLKDV_DIVIDE - 1);

  logic [DV_W-1:0] dv_count;

  // Integer divider: modulo counter over locked cycles, strobing on its last count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dv_count     <= '0;
      clkdv_enable <= 1'b0;
    end else if (locked) begin
      dv_count     <= (dv_count == DV_LAST) ? '0 : (dv_count + DV_W'(1));
      clkdv_enable <= (dv_count == DV_LAST);
    end else begin
      clkdv_enable <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_clock_gen_mux.sv
// tb_clock_gen_mux: directed bench for clock_gen_mux.
// Three instances share stimulus: defaults (2/6), a 3/7 sweep and a 4/4
// constant-high case. Timeline index j counts clock edges since lock.
module tb_clock_gen_mux;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic step_enable = 1'b0;
  logic step_level = 1'b0;

  logic fx_a, game_a, sel_a, locked_a, rst_out_a;
  logic fx_b, game_b, sel_b, locked_b, rst_out_b;
  logic fx_c, game_c, sel_c, locked_c, rst_out_c;
`ifdef CLOCK_GEN_MUX_CLKDV_EN
  logic clkdv_a, clkdv_b, clkdv_c;
`endif

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int lock_at = 0;

  // fx pattern for M=3, D=7 indexed by j % 7 (hand-derived: j%7 in {0,3,5})
  logic [6:0] b_pat = 7'b0101001;

  clock_gen_mux #(.CLKFX_MULTIPLY(2), .CLKFX_DIVIDE(6), .LOCK_CYCLES(16)) dut_a (
    .clock(clock), .reset(reset), .step_enable(step_enable), .step_level(step_level),
    .fx_enable(fx_a), .game_enable(game_a), .sel_active(sel_a),
    .locked(locked_a), .reset_out(rst_out_a)
`ifdef CLOCK_GEN_MUX_CLKDV_EN
    , .clkdv_enable(clkdv_a)
`endif
  );

  clock_gen_mux #(.CLKFX_MULTIPLY(3), .CLKFX_DIVIDE(7), .LOCK_CYCLES(16)) dut_b (
    .clock(clock), .reset(reset), .step_enable(step_enable), .step_level(step_level),
    .fx_enable(fx_b), .game_enable(game_b), .sel_active(sel_b),
    .locked(locked_b), .reset_out(rst_out_b)
`ifdef CLOCK_GEN_MUX_CLKDV_EN
    , .clkdv_enable(clkdv_b)
`endif
  );

  clock_gen_mux #(.CLKFX_MULTIPLY(4), .CLKFX_DIVIDE(4), .LOCK_CYCLES(16)) dut_c (
    .clock(clock), .reset(reset), .step_enable(step_enable), .step_level(step_level),
    .fx_enable(fx_c), .game_enable(game_c), .sel_active(sel_c),
    .locked(locked_c), .reset_out(rst_out_c)
`ifdef CLOCK_GEN_MUX_CLKDV_EN
    , .clkdv_enable(clkdv_c)
`endif
  );

  // Free-running 10-unit clock
  always #5 clock = ~clock;

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic int rel();
    return cyc - lock_at;
  endfunction

  // Hold reset, check reset values, release and watch the lock sequence
  task automatic test_reset();
    logic exp;
    reset = 1'b1;
    repeat (3) tick();
    compared++;
    if ({fx_a, game_a, sel_a, locked_a, rst_out_a} !== 5'b00001) begin
      mismatched++;
      $display("[TB] FAIL reset_state_a: got %b want 00001", {fx_a, game_a, sel_a, locked_a, rst_out_a});
    end
    compared++;
    if ({fx_b, game_b, sel_b, locked_b, rst_out_b} !== 5'b00001) begin
      mismatched++;
      $display("[TB] FAIL reset_state_b: got %b want 00001", {fx_b, game_b, sel_b, locked_b, rst_out_b});
    end
    compared++;
    if ({fx_c, game_c, sel_c, locked_c, rst_out_c} !== 5'b00001) begin
      mismatched++;
      $display("[TB] FAIL reset_state_c: got %b want 00001", {fx_c, game_c, sel_c, locked_c, rst_out_c});
    end
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp = (i >= 16);
      compared++;
      if (locked_a !== exp) begin
        mismatched++;
        $display("[TB] FAIL lock_locked i=%0d: got %b want %b", i, locked_a, exp);
      end
      compared++;
      if (rst_out_a !== !exp) begin
        mismatched++;
        $display("[TB] FAIL lock_reset_out i=%0d: got %b want %b", i, rst_out_a, !exp);
      end
      compared++;
      if ({fx_a, game_a, game_c} !== 3'b000) begin
        mismatched++;
        $display("[TB] FAIL prelock_quiet i=%0d: got %b want 000", i, {fx_a, game_a, game_c});
      end
    end
    compared++;
    if ({locked_b, locked_c} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL lock_bc: got %b want 11", {locked_b, locked_c});
    end
    lock_at = cyc;
  endtask

  // Run mode: fx/game cadence for 2/6, 3/7 window counts and 4/4 constant high
  task automatic test_run();
    int j;
    int cnt_a = 0;
    int cnt_b = 0;
    logic prev_b = 1'b0;
    logic exp_fx, exp_game, exp_b;
    for (int k = 0; k < 60; k++) begin
      tick();
      j = rel();
      exp_fx = (j % 3 == 0);
      exp_game = (j >= 4) && ((j - 1) % 3 == 0);
      exp_b = b_pat[j % 7];
      if (fx_a === 1'b1) cnt_a++;
      if (j <= 56 && fx_b === 1'b1) cnt_b++;
      compared++;
      if (fx_a !== exp_fx) begin
        mismatched++;
        $display("[TB] FAIL run_fx j=%0d: got %b want %b", j, fx_a, exp_fx);
      end
      compared++;
      if (game_a !== exp_game) begin
        mismatched++;
        $display("[TB] FAIL run_game j=%0d: got %b want %b", j, game_a, exp_game);
      end
      compared++;
      if (sel_a !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL run_sel j=%0d: got %b want 0", j, sel_a);
      end
      compared++;
      if (fx_b !== exp_b) begin
        mismatched++;
        $display("[TB] FAIL sweep_fx j=%0d: got %b want %b", j, fx_b, exp_b);
      end
      compared++;
      if (prev_b === 1'b1 && fx_b === 1'b1) begin
        mismatched++;
        $display("[TB] FAIL sweep_adjacent j=%0d: got 11 want no back-to-back", j);
      end
      compared++;
      if (fx_c !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL full_rate_fx j=%0d: got %b want 1", j, fx_c);
      end
      prev_b = fx_b;
    end
    compared++;
    if (cnt_a != 20) begin
      mismatched++;
      $display("[TB] FAIL run_count: got %0d want 20", cnt_a);
    end
    compared++;
    if (cnt_b != 24) begin
      mismatched++;
      $display("[TB] FAIL sweep_count: got %0d want 24", cnt_b);
    end
  endtask

  // Switch to step mode at an idle slot, then one step edge gives one pulse
  task automatic test_step();
    int j;
    logic exp_sel, exp_game;
    step_enable = 1'b1;
    while (rel() < 75) begin
      tick();
      j = rel();
      exp_sel = (j >= 63);
      exp_game = (j == 61) || (j == 69);
      compared++;
      if (sel_a !== exp_sel) begin
        mismatched++;
        $display("[TB] FAIL step_sel j=%0d: got %b want %b", j, sel_a, exp_sel);
      end
      compared++;
      if (game_a !== exp_game) begin
        mismatched++;
        $display("[TB] FAIL step_game j=%0d: got %b want %b", j, game_a, exp_game);
      end
      if (j == 65) step_level = 1'b1;
      if (j == 70) step_level = 1'b0;
      if (j == 75) step_level = 1'b1;
    end
  endtask

  // Switch back to run while both an fx strobe and a step pulse are in flight
  task automatic test_back_to_back();
    int j;
    logic exp_sel, exp_game;
    while (rel() < 90) begin
      tick();
      j = rel();
      exp_sel = (j <= 79);
      exp_game = (j == 79) || ((j >= 82) && ((j - 1) % 3 == 0));
      compared++;
      if (sel_a !== exp_sel) begin
        mismatched++;
        $display("[TB] FAIL b2b_sel j=%0d: got %b want %b", j, sel_a, exp_sel);
      end
      compared++;
      if (game_a !== exp_game) begin
        mismatched++;
        $display("[TB] FAIL b2b_game j=%0d: got %b want %b", j, game_a, exp_game);
      end
      if (j == 76) step_enable = 1'b0;
    end
  endtask

  // Asynchronous reset mid-run, then relock and restart of the strobes
  task automatic test_reset_async();
    int j;
    logic exp, exp_fx;
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if ({fx_a, game_a, sel_a, locked_a, rst_out_a} !== 5'b00001) begin
      mismatched++;
      $display("[TB] FAIL async_reset_a: got %b want 00001", {fx_a, game_a, sel_a, locked_a, rst_out_a});
    end
    compared++;
    if ({fx_c, locked_c, rst_out_c} !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL async_reset_c: got %b want 001", {fx_c, locked_c, rst_out_c});
    end
`ifdef CLOCK_GEN_MUX_CLKDV_EN
    compared++;
    if ({clkdv_a, clkdv_b, clkdv_c} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL async_reset_clkdv: got %b want 000", {clkdv_a, clkdv_b, clkdv_c});
    end
`endif
    step_level = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp = (i >= 16);
      compared++;
      if ({locked_a, rst_out_a} !== {exp, !exp}) begin
        mismatched++;
        $display("[TB] FAIL relock i=%0d: got %b want %b", i, {locked_a, rst_out_a}, {exp, !exp});
      end
    end
    lock_at = cyc;
    for (int k = 0; k < 9; k++) begin
      tick();
      j = rel();
      exp_fx = (j % 3 == 0);
      compared++;
      if (fx_a !== exp_fx) begin
        mismatched++;
        $display("[TB] FAIL relock_fx j=%0d: got %b want %b", j, fx_a, exp_fx);
      end
`ifdef CLOCK_GEN_MUX_CLKDV_EN
      compared++;
      if (clkdv_a !== exp_fx) begin
        mismatched++;
        $display("[TB] FAIL relock_clkdv j=%0d: got %b want %b", j, clkdv_a, exp_fx);
      end
`endif
    end
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence
  initial begin
    test_reset();
    test_run();
    test_step();
    test_back_to_back();
    test_reset_async();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
